// File: rtl/cam_tag_reader.sv
// CAM tag read-out engine: snapshots the match tags, walks the set rows in
// ascending order and streams (row, word) beats over a valid/ready handshake.
module cam_tag_reader #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 128,
    parameter int ADDR_W     = $clog2(CELL_QUANT)
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CELL_QUANT-1:0] tags_in,
    output logic [ADDR_W-1:0]     cam_addr,
    input  logic [WORD_SIZE-1:0]  cam_doutb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [WORD_SIZE-1:0]  out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       match_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_READ,
        S_OUT,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CELL_QUANT-1:0] pending;
    logic [ADDR_W-1:0]     idx;
    logic                  any;
    logic                  take;

    // Lowest set bit wins: scanning downwards lets each lower hit overwrite.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        idx = '0;
        for (int i = CELL_QUANT - 1; i >= 0; i--) begin
            if (pending[i]) idx = ADDR_W'(i);
        end
    end

    assign any = |pending;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_next = S_SCAN;
                S_SCAN:  state_next = any ? S_READ : S_DONE;
                S_READ:  state_next = S_OUT;
                S_OUT:   if (take) state_next = out_last ? S_DONE : S_SCAN;
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
        take = (state == S_OUT) && out_valid && out_ready;
    end

    // Datapath: abort drops the beat in flight but keeps the delivered count.
    always_ff @(posedge clock) begin
        if (!rst) begin
            pending     <= '0;
            cam_addr    <= '0;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_data    <= '0;
            out_last    <= 1'b0;
            match_count <= '0;
        end else if (abort) begin
            pending   <= '0;
            cam_addr  <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pending     <= tags_in;
                        match_count <= '0;
                    end
                end
                S_SCAN: begin
                    if (any) begin
                        cam_addr     <= idx;
                        pending[idx] <= 1'b0;
                    end
                end
                S_READ: begin
                    out_data  <= cam_doutb;
                    out_addr  <= cam_addr;
                    out_last  <= (pending == '0);
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (take) begin
                        out_valid   <= 1'b0;
                        out_last    <= 1'b0;
                        match_count <= match_count + (ADDR_W + 1)'(1);
                    end
                end
                S_DONE: begin
                    cam_addr <= '0;
                    out_addr <= '0;
                    out_data <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
